// File: rtl/bf_pkg.sv
// Shared tape-machine encodings: op codes, program word constants and sequencer states.
// Used by the op sequencer and the tape control unit so the op encoding is defined once.
package bf_pkg;

  typedef enum logic [2:0] {
    OP_RIGHT = 3'd0,
    OP_LOAD  = 3'd1,
    OP_LEFT  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_OPEN  = 3'd5,
    OP_CLOSE = 3'd6,
    OP_OUT   = 3'd7
  } op_e;

  localparam logic [3:0] WORD_HALT  = 4'b1000;
  localparam logic [3:0] WORD_OPEN  = 4'b0101;
  localparam logic [3:0] WORD_CLOSE = 4'b0110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_EVAL,
    ST_SCAN_FWD,
    ST_SCAN_BACK,
    ST_HALT,
    ST_ERROR
  } seq_state_e;

endpackage

// File: rtl/bf_depth_ctr.sv
// Bracket nesting counter: load-to-one, saturating up/down; one-cycle update,
// flags combinational from the registered count, no backpressure.
module bf_depth_ctr #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_one,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               zero,
  output logic               at_max
);

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (load_one) begin
      depth <= DEPTH_W'(1);
    end else if (inc && !at_max) begin
      depth <= depth + DEPTH_W'(1);
    end else if (dec && !zero) begin
      depth <= depth - DEPTH_W'(1);
    end
  end

  assign zero   = (depth == '0);
  assign at_max = (depth == '1);

endmodule

// File: rtl/bf_op_sequencer.sv
// Program fetch/decode front end with internal bracket resolution; 3 cycles min per issued op,
// op held on op_valid until op_ready, loop scans take 2 cycles per skipped word.
module bf_op_sequencer
  import bf_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_rd,
  input  logic [3:0]        prog_data,
  output logic [2:0]        op,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              cell_zero,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [ADDR_W-1:0] pc
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  op_e               op_q, op_d;
  logic              scan_dec_q, scan_dec_d;

  logic               dc_load, dc_inc, dc_dec;
  logic [DEPTH_W-1:0] depth;
  logic               depth_zero, depth_max, depth_one;

  logic              pc_top, pc_bot;
  logic [ADDR_W-1:0] pc_inc, pc_dec, adv_pc;
  seq_state_e        adv_state;
  logic              w_open, w_close, w_halt;

  bf_depth_ctr #(.DEPTH_W(DEPTH_W)) u_depth (
    .clk      (clk),
    .rst      (rst),
    .load_one (dc_load),
    .inc      (dc_inc),
    .dec      (dc_dec),
    .depth    (depth),
    .zero     (depth_zero),
    .at_max   (depth_max)
  );

  assign depth_one = (depth == DEPTH_W'(1));
  assign pc_top    = (pc_q == '1);
  assign pc_bot    = (pc_q == '0);
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign pc_dec    = pc_q - ADDR_W'(1);
  // Moving to the next word parks on the offending address instead of wrapping.
  assign adv_pc    = pc_top ? pc_q : pc_inc;
  assign adv_state = pc_top ? ST_ERROR : ST_FETCH;
  assign w_open    = (prog_data == WORD_OPEN);
  assign w_close   = (prog_data == WORD_CLOSE);
  assign w_halt    = (prog_data == WORD_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      op_q       <= OP_RIGHT;
      scan_dec_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      scan_dec_q <= scan_dec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    scan_dec_d = 1'b0;
    dc_load    = 1'b0;
    dc_inc     = 1'b0;
    dc_dec     = 1'b0;
    prog_rd    = 1'b0;
    op_valid   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        prog_rd = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!prog_data[3]) begin
          op_d    = op_e'(prog_data[2:0]);
          state_d = (w_open || w_close) ? ST_EVAL : ST_ISSUE;
        end else if (w_halt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = adv_pc;
          state_d = adv_state;
        end
      end
      ST_ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) begin
          pc_d    = adv_pc;
          state_d = adv_state;
        end
      end
      ST_EVAL: begin
        // cell_zero is only meaningful once the control unit is idle.
        if (op_ready) begin
          if (op_q == OP_OPEN && cell_zero) begin
            dc_load = 1'b1;
            if (pc_top) state_d = ST_ERROR;
            else begin
              pc_d    = pc_inc;
              state_d = ST_SCAN_FWD;
            end
          end else if (op_q == OP_CLOSE && !cell_zero) begin
            dc_load = 1'b1;
            if (pc_bot) state_d = ST_ERROR;
            else begin
              pc_d    = pc_dec;
              state_d = ST_SCAN_BACK;
            end
          end else begin
            pc_d    = adv_pc;
            state_d = adv_state;
          end
        end
      end
      ST_SCAN_FWD: begin
        if (!scan_dec_q) begin
          prog_rd    = 1'b1;
          scan_dec_d = 1'b1;
        end else if (w_halt || (w_open && depth_max) || (w_close && depth_zero)) begin
          state_d = ST_ERROR;
        end else if (w_close && depth_one) begin
          dc_dec  = 1'b1;
          pc_d    = adv_pc;
          state_d = adv_state;
        end else begin
          dc_inc = w_open;
          dc_dec = w_close;
          if (pc_top) state_d = ST_ERROR;
          else pc_d = pc_inc;
        end
      end
      ST_SCAN_BACK: begin
        if (!scan_dec_q) begin
          prog_rd    = 1'b1;
          scan_dec_d = 1'b1;
        end else if (w_halt || (w_close && depth_max) || (w_open && depth_zero)) begin
          state_d = ST_ERROR;
        end else if (w_open && depth_one) begin
          // Matching '[' found: resume just after it, like the forward case.
          dc_dec  = 1'b1;
          pc_d    = adv_pc;
          state_d = adv_state;
        end else begin
          dc_inc = w_close;
          dc_dec = w_open;
          if (pc_bot) state_d = ST_ERROR;
          else pc_d = pc_dec;
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  assign prog_addr = pc_q;
  assign pc        = pc_q;
  assign op        = op_q;
  assign halted    = (state_q == ST_HALT);
  assign error     = (state_q == ST_ERROR);
  assign busy      = !(state_q == ST_IDLE || state_q == ST_HALT || state_q == ST_ERROR);

endmodule

// File: tb/tb_bf_op_sequencer.sv
// Directed bench for bf_op_sequencer: program table plus hand sequences for backpressure,
// pc overrun and mid-op reset; a tape-cell model drives cell_zero from issued ops.
module tb_bf_op_sequencer;
  import bf_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] prog_addr;
  logic       prog_rd;
  logic [3:0] prog_data;
  logic [2:0] op;
  logic       op_valid, op_ready, cell_zero;
  logic       busy, halted, error;
  logic [7:0] pc;

  logic [3:0] mem [256];
  logic [7:0] cell_base = 8'd0;
  logic [7:0] cell_net  = 8'd0;
  logic [2:0] got_ops[$];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] prog;     // word 0 in the top nibble
    logic [7:0]  cell0;
    logic [31:0] exp_ops;  // op 0 in the top nibble
    logic [3:0]  nops;
    logic        exp_halt;
    logic        exp_err;
    logic [7:0]  exp_pc;
  } vec_t;

  localparam int NV = 8;
  vec_t  vecs [NV];
  string names [NV];
  int    cycles [NV];

  bf_op_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_addr (prog_addr),
    .prog_rd   (prog_rd),
    .prog_data (prog_data),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .cell_zero (cell_zero),
    .busy      (busy),
    .halted    (halted),
    .error     (error),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (prog_rd) prog_data <= mem[prog_addr];

  assign cell_zero = ((cell_base + cell_net) == 8'd0);

  // Transfers happen on the next rising edge; record them half a cycle early.
  always @(negedge clk) begin
    if (rst === 1'b0 && op_valid === 1'b1 && op_ready === 1'b1) begin
      got_ops.push_back(op);
      if (op == OP_INC) cell_net = cell_net + 8'd1;
      if (op == OP_DEC) cell_net = cell_net - 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   base, n, a;
    v = vecs[idx];
    for (int i = 0; i < 256; i++) mem[i] = WORD_HALT;
    for (int w = 0; w < 8; w++) mem[w] = v.prog[31-4*w -: 4];
    cell_base = v.cell0 - cell_net;
    base = got_ops.size();
    op_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    cycles[idx] = n;
    chk({names[idx], "_done"}, int'(busy), 0);
    chk({names[idx], "_nops"}, got_ops.size() - base, int'(v.nops));
    for (int k = 0; k < int'(v.nops); k++) begin
      a = -1;
      if (base + k < got_ops.size()) a = int'(got_ops[base+k]);
      chk({names[idx], "_op"}, a, int'(v.exp_ops[31-4*k -: 4]));
    end
    chk({names[idx], "_halted"}, int'(halted), int'(v.exp_halt));
    chk({names[idx], "_error"}, int'(error), int'(v.exp_err));
    chk({names[idx], "_pc"}, int'(pc), int'(v.exp_pc));
  endtask

  initial begin
    int base, n;

    //                 prog          cell   exp ops      n   H     E     pc
    vecs[0] = '{32'h3337_8888, 8'd0, 32'h3337_0000, 4'd4, 1'b1, 1'b0, 8'd4};
    names[0] = "incs_out";
    vecs[1] = '{32'h5368_8888, 8'd0, 32'h0000_0000, 4'd0, 1'b1, 1'b0, 8'd3};
    names[1] = "skip_loop";
    vecs[2] = '{32'h5354_6688, 8'd0, 32'h0000_0000, 4'd0, 1'b1, 1'b0, 8'd6};
    names[2] = "nested_skip";
    vecs[3] = '{32'h3546_8888, 8'd2, 32'h3444_0000, 4'd4, 1'b1, 1'b0, 8'd4};
    names[3] = "loop_3x";
    vecs[4] = '{32'h5588_8888, 8'd0, 32'h0000_0000, 4'd0, 1'b0, 1'b1, 8'd2};
    names[4] = "unbal_open";
    vecs[5] = '{32'h0129_7F48, 8'd0, 32'h0127_4000, 4'd5, 1'b1, 1'b0, 8'd7};
    names[5] = "all_ops_nop";
    vecs[6] = '{32'h5468_8888, 8'd1, 32'h4000_0000, 4'd1, 1'b1, 1'b0, 8'd3};
    names[6] = "loop_once";
    vecs[7] = '{32'h3688_8888, 8'd0, 32'h3000_0000, 4'd1, 1'b0, 1'b1, 8'd0};
    names[7] = "back_underflow";

    for (int i = 0; i < 256; i++) mem[i] = WORD_HALT;
    rst = 1'b1;
    start = 1'b0;
    op_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_prog_rd", int'(prog_rd), 0);
    chk("rst_op", int'(op), 0);

    for (int i = 0; i < NV; i++) run_vec(i);
    chk("incs_out_busy_cycles", cycles[0], 14);

    // Program of NOPs only: must stop at the last address rather than wrap.
    for (int i = 0; i < 256; i++) mem[i] = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("overrun_error", int'(error), 1);
    chk("overrun_halted", int'(halted), 0);
    chk("overrun_pc", int'(pc), 255);

    // Backpressure: hold op_ready low for 5 ISSUE cycles, poke start meanwhile.
    for (int i = 0; i < 256; i++) mem[i] = WORD_HALT;
    mem[0] = 4'h9;
    mem[1] = 4'h3;
    mem[2] = 4'h7;
    base = got_ops.size();
    op_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (op_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("hold_reach_issue", int'(op_valid), 1);
    chk("hold_pc", int'(pc), 1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", int'(op_valid), 1);
      chk("hold_op", int'(op), 3);
      if (k == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("hold_start_ignored_pc", int'(pc), 1);
    chk("hold_no_early_xfer", got_ops.size() - base, 0);
    op_ready = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("hold_xfers", got_ops.size() - base, 2);
    if (got_ops.size() - base == 2) begin
      chk("hold_xfer0", int'(got_ops[base]), 3);
      chk("hold_xfer1", int'(got_ops[base+1]), 7);
    end
    chk("hold_halted", int'(halted), 1);

    // Reset while an op is being offered: it must vanish and never replay.
    for (int i = 0; i < 256; i++) mem[i] = WORD_HALT;
    mem[0] = 4'h3;
    base = got_ops.size();
    op_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (op_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("midrst_reach_issue", int'(op_valid), 1);
    rst = 1'b1;
    tick();
    chk("midrst_op_valid", int'(op_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pc", int'(pc), 0);
    chk("midrst_op", int'(op), 0);
    rst = 1'b0;
    op_ready = 1'b1;
    repeat (4) tick();
    chk("midrst_no_replay_valid", int'(op_valid), 0);
    chk("midrst_idle", int'(busy), 0);
    chk("midrst_no_xfer", got_ops.size() - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
